// File: rtl/demux_1x3_stream.sv
// One input stream fanned out to three one-entry registered output slots.
// s0 has priority and selects slot 1; otherwise s1 selects slot 2; otherwise slot 0.
module demux_1x3_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              s0,
    input  logic              s1,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [DATA_W-1:0] out2_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [1:0]        sel;
    logic [2:0]        rdy;
    logic [2:0]        full_q;
    logic [2:0]        full_d;
    logic [2:0]        load;
    logic [2:0]        drain;
    logic              accept;
    logic [DATA_W-1:0] data_q [3];
    logic [CNT_W-1:0]  cnt_q  [3];
    logic [CNT_W-1:0]  cnt_d  [3];

    assign rdy = {out2_ready, out1_ready, out0_ready};

    always_comb begin
        sel = 2'd0;
        if (s0) begin
            sel = 2'd1;
        end else if (s1) begin
            sel = 2'd2;
        end
    end

    // A full slot can still accept when it drains in the same cycle.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            2'd0:    in_ready = !full_q[0] | rdy[0];
            2'd1:    in_ready = !full_q[1] | rdy[1];
            2'd2:    in_ready = !full_q[2] | rdy[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load   = 3'b000;
        drain  = 3'b000;
        full_d = full_q;
        for (int k = 0; k < 3; k++) begin
            load[k]   = accept & (sel == 2'(k));
            drain[k]  = full_q[k] & rdy[k];
            full_d[k] = load[k] | (full_q[k] & !drain[k]);
            cnt_d[k]  = cnt_q[k];
            if (clr_cnt) begin
                cnt_d[k] = '0;
            end else if (load[k] && (cnt_q[k] != CntMax)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int k = 0; k < 3; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out0_valid = full_q[0];
    assign out1_valid = full_q[1];
    assign out2_valid = full_q[2];
    assign out0_data  = data_q[0];
    assign out1_data  = data_q[1];
    assign out2_data  = data_q[2];
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];
    assign cnt2       = cnt_q[2];

endmodule

// File: tb/tb_demux_1x3_stream.sv
// Directed bench for demux_1x3_stream: queue-based reference model checked every
// negative edge, plus literal expectations at key points of each scenario.
module tb_demux_1x3_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          s0 = 1'b0;
    logic          s1 = 1'b0;
    logic          out0_valid, out1_valid, out2_valid;
    logic          out0_ready = 1'b1;
    logic          out1_ready = 1'b1;
    logic          out2_ready = 1'b1;
    logic [DW-1:0] out0_data, out1_data, out2_data;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] cnt0, cnt1, cnt2;

    int n_checks = 0;
    int n_fails  = 0;

    demux_1x3_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .s0         (s0),
        .s1         (s1),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .clr_cnt    (clr_cnt),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each destination is a queue of capacity one.
    logic [DW-1:0] mq [3][$];
    int            mcnt [3] = '{0, 0, 0};
    logic [2:0]    rdy;
    logic [DW-1:0] od [3];
    logic [2:0]    ov;
    logic [CW-1:0] oc [3];

    assign rdy = {out2_ready, out1_ready, out0_ready};
    assign od  = '{out0_data, out1_data, out2_data};
    assign ov  = {out2_valid, out1_valid, out0_valid};
    assign oc  = '{cnt0, cnt1, cnt2};

    function automatic int dest(input logic a0, input logic a1);
        if (a0) return 1;
        if (a1) return 2;
        return 0;
    endfunction

    function automatic logic model_ready(input int d);
        return (mq[d].size() == 0) || rdy[d];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
    endtask

    always @(negedge rst_n) model_reset();

    // Upstream hold-while-stalled tracking.
    logic          prev_block = 1'b0;
    logic [DW-1:0] prev_in_data;
    logic          prev_s0, prev_s1;

    always @(posedge clk) begin
        int  d;
        logic acc;
        if (!rst_n) begin
            model_reset();
            prev_block = 1'b0;
        end else begin
            if (prev_block && in_valid) begin
                chk("upstream_hold", {in_data, s1, s0}, {prev_in_data, prev_s1, prev_s0});
            end
            d   = dest(s0, s1);
            acc = in_valid && model_ready(d);
            prev_block   = in_valid && !acc;
            prev_in_data = in_data;
            prev_s0      = s0;
            prev_s1      = s1;
            for (int k = 0; k < 3; k++) begin
                if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
            end
            if (acc) mq[d].push_back(in_data);
            for (int k = 0; k < 3; k++) begin
                if (clr_cnt) mcnt[k] = 0;
                else if (acc && d == k && mcnt[k] < (2 ** CW) - 1) mcnt[k]++;
            end
        end
    end

    // Output hold-until-ready tracking.
    logic [2:0]    held = 3'b000;
    logic [DW-1:0] held_data [3];

    always @(negedge rst_n) held = 3'b000;

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready(dest(s0, s1))});
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out%0d_valid", k), {31'd0, ov[k]}, {31'd0, mq[k].size() > 0});
            if (mq[k].size() > 0) chk($sformatf("out%0d_data", k), {24'd0, od[k]}, {24'd0, mq[k][0]});
            chk($sformatf("cnt%0d", k), {28'd0, oc[k]}, mcnt[k]);
            if (held[k]) begin
                chk($sformatf("out%0d_hold_valid", k), {31'd0, ov[k]}, 32'd1);
                chk($sformatf("out%0d_hold_data", k), {24'd0, od[k]}, {24'd0, held_data[k]});
            end
            held[k]      = rst_n && ov[k] && !rdy[k];
            held_data[k] = od[k];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic a1, input logic a0);
        in_valid = 1'b1;
        in_data  = d;
        s1       = a1;
        s0       = a0;
    endtask

    initial begin
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valids", {29'd0, ov}, 32'd0);
        chk("rst_data", {8'd0, out0_data, out1_data, out2_data}, 32'd0);
        chk("rst_cnts", {20'd0, cnt0, cnt1, cnt2}, 32'd0);
        rst_n = 1'b1;

        // Select decode, all destinations ready.
        send(8'hA0, 1'b0, 1'b0); step();
        chk("dec_out0", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hA0});
        send(8'hA1, 1'b0, 1'b1); step();
        chk("dec_out1a", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hA1});
        send(8'hA2, 1'b1, 1'b0); step();
        chk("dec_out2", {23'd0, out2_valid, out2_data}, {23'd0, 1'b1, 8'hA2});
        send(8'hA3, 1'b1, 1'b1); step();
        chk("dec_out1b", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hA3});
        chk("dec_cnts", {20'd0, cnt0, cnt1, cnt2}, {20'd0, 4'd1, 4'd2, 4'd1});
        in_valid = 1'b0; step();

        // Backpressure on slot 2.
        out2_ready = 1'b0;
        send(8'hB0, 1'b1, 1'b0); step();
        send(8'hB1, 1'b1, 1'b0); #1;
        chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        step(); step();
        chk("bp_hold_data", {24'd0, out2_data}, {24'd0, 8'hB0});
        out2_ready = 1'b1; #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        out2_ready = 1'b0;
        in_valid   = 1'b0;
        chk("bp_second", {23'd0, out2_valid, out2_data}, {23'd0, 1'b1, 8'hB1});

        // Independence: slot 2 stalled, slot 0 still flows.
        send(8'h55, 1'b0, 1'b0); #1;
        chk("ind_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("ind_out0", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'h55});
        chk("ind_out2", {23'd0, out2_valid, out2_data}, {23'd0, 1'b1, 8'hB1});

        // Clear counters; slots untouched.
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        chk("clr_cnts", {20'd0, cnt0, cnt1, cnt2}, 32'd0);
        chk("clr_slot2", {23'd0, out2_valid, out2_data}, {23'd0, 1'b1, 8'hB1});

        // Streaming into slot 1.
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 1'b0, 1'b1); #1;
            chk("str_ready", {31'd0, in_ready}, 32'd1);
            step();
            chk("str_out1", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'(i)});
        end
        in_valid = 1'b0;
        chk("str_cnt1", {28'd0, cnt1}, 32'd10);

        // Saturation then clear coincident with an accept.
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h60 + i), 1'b0, 1'b0); step();
        end
        chk("sat_cnt0", {28'd0, cnt0}, 32'd15);
        send(8'h77, 1'b0, 1'b0);
        clr_cnt = 1'b1; step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        chk("sat_clr_cnt0", {28'd0, cnt0}, 32'd0);
        chk("sat_clr_slot0", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'h77});
        step();

        // Fill all three slots stalled, then reset between edges.
        out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        send(8'hC0, 1'b0, 1'b0); step();
        send(8'hC1, 1'b0, 1'b1); step();
        in_valid = 1'b0;
        chk("pre_rst_valids", {29'd0, ov}, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {29'd0, ov}, 32'd0);
        chk("mid_rst_cnts", {20'd0, cnt0, cnt1, cnt2}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        send(8'hD1, 1'b0, 1'b1); step();
        in_valid = 1'b0;
        chk("post_rst_out1", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hD1});
        chk("post_rst_cnt1", {28'd0, cnt1}, 32'd1);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/demux_1x3_stream.md
Name: demux_1x3_stream

Overview:
- Counterpart of the 3-to-1 select mux: one input stream fans out to three output streams.
- Each transfer goes to one destination, chosen by the same s0/s1 priority encoding the mux uses to select a source.
- Each output has a one-entry registered slot and a valid/ready handshake.
- Per-destination saturating transfer counters are provided for debug and for testbench scoreboarding.

Parameters:
DATA_W, 8, width of the payload carried on each stream
CNT_W, 8, width of each per-output transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transfer offered
in_ready  output  1  block can accept the offered transfer this cycle
in_data  input  DATA_W  payload
s0  input  1  select bit 0, higher priority
s1  input  1  select bit 1
out0_valid  output  1  slot 0 holds data
out0_ready  input  1  downstream 0 accepts
out0_data  output  DATA_W  slot 0 payload
out1_valid  output  1  slot 1 holds data
out1_ready  input  1  downstream 1 accepts
out1_data  output  DATA_W  slot 1 payload
out2_valid  output  1  slot 2 holds data
out2_ready  input  1  downstream 2 accepts
out2_data  output  DATA_W  slot 2 payload
clr_cnt  input  1  synchronous clear of all counters
cnt0  output  CNT_W  transfers delivered into slot 0
cnt1  output  CNT_W  transfers delivered into slot 1
cnt2  output  CNT_W  transfers delivered into slot 2

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Destination select (combinational):
  - s0=1 selects slot 1, regardless of s1.
  - s0=0, s1=1 selects slot 2.
  - s0=0, s1=0 selects slot 0.
  - Every code is legal.
- Slot state: each slot k holds a full flag and a data register. outk_valid = full[k] and outk_data = data register k, both registered.
- in_ready is combinational: in_ready = !full[sel] | outsel_ready. It never depends on in_valid.
- Accept: a transfer is accepted when in_valid & in_ready. At that clock edge, slot sel loads in_data and full[sel] is set.
- Latency: data appears on outk one cycle after acceptance.
- Drain: a slot drains when outk_valid & outk_ready. full[k] clears unless that slot is loaded in the same cycle.
- Simultaneous load and drain of the same slot:
  - full stays 1 and data is replaced.
  - Sustained throughput is 1 transfer/cycle per destination.
- Slots drain independently: one stalled destination does not block traffic selected to another destination.
- Upstream rule: in_data, s0 and s1 are held stable while in_valid=1 and in_ready=0. Changing them before acceptance is a protocol violation; the bench flags it.
- Output rule: once outk_valid rises, it stays high and outk_data stays stable until outk_ready is sampled high.
- Counters:
  - cntk increments by 1 on each acceptance into slot k.
  - Counters saturate at 2^CNT_W-1; there is no wrap.
  - clr_cnt=1 sets all counters to 0 at the next edge and has priority over an increment in the same cycle.
  - clr_cnt does not affect slots.
- Reset values: all full flags 0, all outk_valid 0, all outk_data 0, all cntk 0.
- in_ready during reset: 1, since all slots are empty.
- Reset mid-operation: held data is discarded immediately (asynchronous). No transfer is delivered after rst_n falls.
- Deassertion: the first accept can occur on the first rising edge with rst_n=1.

Test Plan:
- Select decode: with all outk_ready=1, send 0xA0 (s1s0=00), 0xA1 (01), 0xA2 (10), 0xA3 (11) on consecutive cycles.
  - Required: out0 gets 0xA0; out1 gets 0xA1 then 0xA3; out2 gets 0xA2, each one cycle after acceptance.
  - Required: cnt0=1, cnt1=2, cnt2=1.
- Backpressure: hold out2_ready=0 and send two items to slot 2.
  - Required: the first is accepted; in_ready=0 for the second while s1s0=10; out2_data stays at the first value.
  - Raising out2_ready for 1 cycle: the second item is accepted in that same cycle and appears on the next cycle.
- Independence: slot 2 is full and stalled; send 0x55 with s1s0=00.
  - Required: in_ready=1 and out0 shows 0x55 next cycle; out2 is unchanged.
- Streaming: out1_ready=1, s0=1, in_valid=1 for 10 cycles with data 0..9.
  - Required: in_ready stays 1 throughout; out1 shows 0..9 on consecutive cycles; cnt1=10.
- Counter saturation and clear: with CNT_W=4, send 20 items to slot 0.
  - Required: cnt0=15.
  - Assert clr_cnt in the same cycle as an accept into slot 0: cnt0=0.
- Reset mid-operation: with all three slots full and stalled, pulse rst_n low between clock edges.
  - Required: all outk_valid fall immediately with no clock edge, and all counters read 0.
  - After release, a new item to slot 1 is delivered normally.
